divider: RTL and testbench



---
 rtl/divider_pkg.sv | 14 +
 rtl/divider_step.sv | 33 +++
 rtl/divider.sv | 93 +++++++++
 tb/tb_divider.sv | 134 +++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared constants and state encoding for the 8-bit restoring divider.
package divider_pkg;

  localparam int WIDTH      = 8;
  localparam int ITERATIONS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage : divider_pkg

// File: rtl/divider_step.sv
// One combinational restoring-division iteration on the {A,W} pair.
module divider_step
  import divider_pkg::*;
(
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] w_next
);

  logic [WIDTH:0]   a_shift_s;
  logic [WIDTH-1:0] w_shift_s;
  logic [WIDTH:0]   diff_s;

  // Shift {A,W} left, trial-subtract M, and restore when the result goes negative.
  always_comb begin
    a_shift_s = {a[WIDTH-1:0], w[WIDTH-1]};
    w_shift_s = {w[WIDTH-2:0], 1'b0};
    diff_s    = a_shift_s - {1'b0, m};
    a_next    = a_shift_s;
    w_next    = w_shift_s;
    if (diff_s[WIDTH] == 1'b1) begin
      // Trial subtraction borrowed: keep the shifted remainder, quotient bit 0.
      a_next = a_shift_s;
      w_next = w_shift_s;
    end else begin
      a_next = diff_s;
      w_next = {w_shift_s[WIDTH-1:1], 1'b1};
    end
  end

endmodule : divider_step

// File: rtl/divider.sv
// 8-bit unsigned restoring divider: dividend then divisor on data_in,
// eight iterations, quotient held on Q while done is high.
module divider
  import divider_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] Q,
  output logic             done
);

  localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);

  state_t           state_r;
  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] m_r;
  logic [3:0]       cnt_r;
  logic [WIDTH-1:0] q_r;
  logic             done_r;

  logic [WIDTH:0]   a_next_s;
  logic [WIDTH-1:0] w_next_s;

  divider_step u_step (
    .a      (a_r),
    .w      (w_r),
    .m      (m_r),
    .a_next (a_next_s),
    .w_next (w_next_s)
  );

  assign Q    = q_r;
  assign done = done_r;

  // Control FSM, iteration counter and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      w_r     <= '0;
      m_r     <= '0;
      cnt_r   <= 4'd0;
      q_r     <= '0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            w_r     <= data_in;
            a_r     <= '0;
            state_r <= LOAD_B;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD_B: begin
          m_r     <= data_in;
          cnt_r   <= 4'd0;
          state_r <= CALC;
        end
        CALC: begin
          a_r   <= a_next_s;
          w_r   <= w_next_s;
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == LAST_ITER) begin
            q_r     <= w_next_s;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          // A held start must drop before another division can begin.
          if (start) begin
            state_r <= DONE;
          end else begin
            done_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule : divider

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected quotients,
// a monitor pops and compares on each rising edge of done.
module tb_divider;
  import divider_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic [7:0] Q;
  logic       done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] sb_q[$];
  logic       done_q = 1'b0;
  logic [7:0] last_q;

  divider dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .Q       (Q),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: compare Q against the oldest expected quotient when done rises.
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        check("q_result", int'(Q), int'(sb_q.pop_front()));
      end
    end
    done_q <= done;
  end

  // Issue one division; expected quotient goes to the scoreboard.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input bit hold);
    int k;
    @(negedge clk);
    start   = 1'b1;
    data_in = a;
    @(negedge clk);
    data_in = b;
    start   = hold;
    sb_q.push_back(exp);
    k = 1;
    while (!done && k < 20) begin
      if (k == 5) begin
        check("q_kept_during_op", int'(Q), int'(last_q));
      end
      @(negedge clk);
      data_in = 8'(k * 37);
      k++;
    end
    check("latency", k, 10);
    last_q = exp;
  endtask

  initial begin
    int bad;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 8'd0;
    last_q  = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_q", int'(Q), 0);
    check("reset_done", int'(done), 0);
    check("reset_state", int'(dut.state_r), int'(IDLE));
    rst = 1'b0;

    do_div(8'd50,  8'd2,  8'd25,  1'b0);
    do_div(8'd255, 8'd16, 8'd15,  1'b0);
    do_div(8'd7,   8'd9,  8'd0,   1'b0);
    do_div(8'd200, 8'd1,  8'd200, 1'b0);
    do_div(8'd100, 8'd0,  8'hFF,  1'b0);

    // Hold start high through DONE: result must be held, no restart.
    do_div(8'd20, 8'd4, 8'd5, 1'b1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      data_in = 8'(i * 11 + 3);
      @(negedge clk);
      if (!done || Q != 8'd5) bad++;
    end
    check("hold_done_q_stable", bad, 0);
    start = 1'b0;
    @(negedge clk);
    check("done_clears", int'(done), 0);
    do_div(8'd9, 8'd3, 8'd3, 1'b0);

    // Reset during the 4th CALC cycle discards the operation.
    @(negedge clk);
    start   = 1'b1;
    data_in = 8'd50;
    @(negedge clk);
    data_in = 8'd2;
    start   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_q", int'(Q), 0);
    check("abort_done", int'(done), 0);
    check("abort_state", int'(dut.state_r), int'(IDLE));
    rst    = 1'b0;
    last_q = 8'd0;
    bad    = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) bad++;
    end
    check("no_done_after_abort", bad, 0);
    do_div(8'd50, 8'd2, 8'd25, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_divider
